// File: rtl/lights_pkg.sv
// Shared definitions for the traffic-lights checker.
// Contents:
//   phase_t      - tracked light phase (RED, RED_AMBER, GREEN, AMBER)
//   err_code_t   - first-error cause reported on err_code
//   state_t      - checker FSM state (UNLOCKED / LOCKED)
//   lamp_dec_t   - result of decoding the {red,amber,green} lamp word
//   decode_lamps - lamp word -> legal flag + phase
//   next_phase   - legal successor of a phase
package lights_pkg;

  typedef enum logic [1:0] {
    PH_RED       = 2'd0,
    PH_RED_AMBER = 2'd1,
    PH_GREEN     = 2'd2,
    PH_AMBER     = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_ORDER   = 2'd2,
    ERR_DWELL   = 2'd3
  } err_code_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  typedef struct packed {
    logic   legal;
    phase_t ph;
  } lamp_dec_t;

  // Lamp word is {red, amber, green}.
  function automatic lamp_dec_t decode_lamps(input logic [2:0] rgb);
    lamp_dec_t d;
    d.legal = 1'b1;
    d.ph    = PH_RED;
    case (rgb)
      3'b100:  d.ph = PH_RED;
      3'b110:  d.ph = PH_RED_AMBER;
      3'b001:  d.ph = PH_GREEN;
      3'b010:  d.ph = PH_AMBER;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // The encodings are numbered in sequence order, so the successor is +1 mod 4.
  function automatic phase_t next_phase(input phase_t p);
    logic [1:0] n;
    n = p + 2'd1;
    return phase_t'(n);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for the lights checker.
// Counts consecutive cycles in the same phase. load_i sets the count to 1,
// inc_i increments it (saturating at MAX_DWELL+1), clr_i zeroes it.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr_i       - clear count to 0 (highest priority)
//   load_i      - load count with 1 (start of a new phase)
//   inc_i       - phase held for another cycle
//   timeout_o   - combinational pulse: this increment is the first to exceed MAX_DWELL
module dwell_timer #(
  parameter int MAX_DWELL = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic inc_i,
  output logic timeout_o
);

  localparam int W = $clog2(MAX_DWELL + 2);
  localparam logic [W-1:0] LIMIT = W'(MAX_DWELL);
  localparam logic [W-1:0] SAT   = W'(MAX_DWELL + 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d   = count_q;
    timeout_o = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = W'(1);
    end else if (inc_i) begin
      if (count_q != SAT) begin
        count_d = count_q + W'(1);
      end
      // Only the step from LIMIT to LIMIT+1 pulses; once saturated, silence.
      if (count_q == LIMIT) begin
        timeout_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lights_checker.sv
// Traffic-lights sequence checker.
// Watches the lamp outputs of a lights controller, locks onto the legal
// sequence RED -> RED_AMBER -> GREEN -> AMBER -> RED and flags illegal
// encodings, out-of-order steps and phases held too long.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   red/amber/green - lamp inputs
//   clr_err      - synchronous clear of err / err_code
//   err          - sticky error flag
//   err_code     - first error cause (lights_pkg::err_code_t)
//   locked       - checker synchronised to a legal phase
//   phase        - tracked phase (lights_pkg::phase_t)
//   cycles       - completed AMBER -> RED transitions, saturating
// All outputs are registered: one cycle from sample to output.
module lights_checker
  import lights_pkg::*;
#(
  parameter int MAX_DWELL = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  input  logic             clr_err,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             locked,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] cycles
);

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic            err_q, err_d;
  err_code_t       err_code_q, err_code_d;

  lamp_dec_t       dec;
  logic            dwell_clr, dwell_load, dwell_inc, dwell_timeout;
  logic            evt;
  err_code_t       evt_code;

  assign dec = decode_lamps({red, amber, green});

  // Kept outside the main comb block: timeout depends on inc, and the main
  // block consumes timeout.
  assign dwell_inc = (state_q == ST_LOCKED) && dec.legal && (dec.ph == phase_q);

  dwell_timer #(
    .MAX_DWELL (MAX_DWELL)
  ) u_dwell (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (dwell_clr),
    .load_i    (dwell_load),
    .inc_i     (dwell_inc),
    .timeout_o (dwell_timeout)
  );

  // Next-state, tracking and error detection. At most one error cause can
  // arise per cycle because the LOCKED branches are mutually exclusive; the
  // if-chain order still encodes illegal > out-of-order > dwell.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cycles_d   = cycles_q;
    dwell_clr  = 1'b0;
    dwell_load = 1'b0;
    evt        = 1'b0;
    evt_code   = ERR_NONE;

    case (state_q)
      ST_UNLOCKED: begin
        if (dec.legal) begin
          state_d    = ST_LOCKED;
          phase_d    = dec.ph;
          dwell_load = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!dec.legal) begin
          evt       = 1'b1;
          evt_code  = ERR_ILLEGAL;
          state_d   = ST_UNLOCKED;
          dwell_clr = 1'b1;
        end else if (dec.ph == phase_q) begin
          if (dwell_timeout) begin
            evt      = 1'b1;
            evt_code = ERR_DWELL;
          end
        end else if (dec.ph == next_phase(phase_q)) begin
          phase_d    = dec.ph;
          dwell_load = 1'b1;
          if ((phase_q == PH_AMBER) && (cycles_q != {CNT_W{1'b1}})) begin
            cycles_d = cycles_q + CNT_W'(1);
          end
        end else begin
          evt        = 1'b1;
          evt_code   = ERR_ORDER;
          phase_d    = dec.ph;
          dwell_load = 1'b1;
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
      end
    endcase
  end

  // Sticky error: the code is captured only from a clean state, so the first
  // cause survives. A clear coinciding with a new error reports the new one.
  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    if (clr_err) begin
      err_d      = evt;
      err_code_d = evt ? evt_code : ERR_NONE;
    end else if (evt) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_code_d = evt_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_UNLOCKED;
      phase_q    <= PH_RED;
      cycles_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cycles_q   <= cycles_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign err      = err_q;
  assign err_code = err_code_q;
  assign locked   = (state_q == ST_LOCKED);
  assign phase    = phase_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_lights_checker.sv
// Directed testbench for lights_checker with an expectation queue.
module tb_lights_checker;

  localparam int MAXD = 16;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          red, amber, green, clr_err;
  logic          err;
  logic [1:0]    err_code;
  logic          locked;
  logic [1:0]    phase;
  logic [CW-1:0] cycles;

  lights_checker #(
    .MAX_DWELL (MAXD),
    .CNT_W     (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .red      (red),
    .amber    (amber),
    .green    (green),
    .clr_err  (clr_err),
    .err      (err),
    .err_code (err_code),
    .locked   (locked),
    .phase    (phase),
    .cycles   (cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [13:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Packed layout: {err, err_code[1:0], locked, phase[1:0], cycles[7:0]}
  task automatic compare(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    obs = {err, err_code, locked, phase, cycles};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed err=%0b code=%0d locked=%0b phase=%0d cycles=%0d, expected err=%0b code=%0d locked=%0b phase=%0d cycles=%0d",
             tag, obs[13], obs[12:11], obs[10], obs[9:8], obs[7:0],
             exp[13], exp[12:11], exp[10], exp[9:8], exp[7:0]);
    end
    $display("[%0t] %s: err=%0b code=%0d locked=%0b phase=%0d cycles=%0d",
             $time, tag, obs[13], obs[12:11], obs[10], obs[9:8], obs[7:0]);
  endtask

  // Drive one sample, queue its expected outcome, compare after the edge.
  task automatic step(input string tag, input logic [2:0] rgb, input logic clr,
                      input logic e_err, input logic [1:0] e_code, input logic e_lock,
                      input logic [1:0] e_ph, input logic [7:0] e_cyc);
    exp_t e;
    @(negedge clk);
    {red, amber, green} = rgb;
    clr_err = clr;
    sb.push_back('{tag, {e_err, e_code, e_lock, e_ph, e_cyc}});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, observed n/a, required one entry", tag);
    end else begin
      e = sb.pop_front();
      compare(e.tag, e.exp);
    end
  endtask

  initial begin
    logic [7:0] cprev, cnow;
    rst_n = 1'b0;
    {red, amber, green} = 3'b000;
    clr_err = 1'b0;
    #1;
    compare("reset_t0", 14'd0);
    @(posedge clk); @(posedge clk); #1;
    compare("reset_hold", 14'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full legal sequence, 3 cycles per phase.
    for (int i = 0; i < 3; i++) step("seq_red",   3'b100, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("seq_ra",    3'b110, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step("seq_green", 3'b001, 0, 0, 0, 1, 2, 0);
    for (int i = 0; i < 3; i++) step("seq_amber", 3'b010, 0, 0, 0, 1, 3, 0);
    step("seq_red_done", 3'b100, 0, 0, 0, 1, 0, 1);

    // Illegal encoding while locked, then relock with error sticky.
    step("illegal_111", 3'b111, 0, 1, 1, 0, 0, 1);
    step("relock_red",  3'b100, 0, 1, 1, 1, 0, 1);
    step("clr_legal",   3'b100, 1, 0, 0, 1, 0, 1);

    // RED directly to GREEN.
    step("order_err",   3'b001, 0, 1, 2, 1, 2, 1);
    step("clr_amber",   3'b010, 1, 0, 0, 1, 3, 1);
    step("cyc2_red",    3'b100, 0, 0, 0, 1, 0, 2);

    // Dwell: RED already sampled once; 15 more are fine, the 17th times out.
    for (int i = 0; i < 15; i++) step("dwell_ok", 3'b100, 0, 0, 0, 1, 0, 2);
    step("dwell_timeout", 3'b100, 0, 1, 3, 1, 0, 2);
    step("dwell_sat",     3'b100, 0, 1, 3, 1, 0, 2);

    // First cause kept: a later illegal encoding leaves code 3.
    step("first_cause", 3'b111, 0, 1, 3, 0, 0, 2);
    step("relock2",     3'b100, 0, 1, 3, 1, 0, 2);

    // Clear coinciding with a new error: the new error wins.
    step("clr_vs_err",  3'b001, 1, 1, 2, 1, 2, 2);
    step("clr_amber2",  3'b010, 1, 0, 0, 1, 3, 2);
    step("cyc3_red",    3'b100, 0, 0, 0, 1, 0, 3);
    step("ra3",         3'b110, 0, 0, 0, 1, 1, 3);
    step("green3",      3'b001, 0, 0, 0, 1, 2, 3);
    step("green3_hold", 3'b001, 0, 0, 0, 1, 2, 3);

    // Asynchronous reset mid-GREEN.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare("rst_async", 14'd0);
    @(posedge clk); #1;
    compare("rst_held", 14'd0);
    @(negedge clk);
    rst_n = 1'b1;
    {red, amber, green} = 3'b111;
    step("unlocked_ignore", 3'b111, 0, 0, 0, 0, 0, 0);
    step("relock_green",    3'b001, 0, 0, 0, 1, 2, 0);
    step("post_rst_amber",  3'b010, 0, 0, 0, 1, 3, 0);
    step("post_rst_red",    3'b100, 0, 0, 0, 1, 0, 1);

    // Run the cycle counter into saturation.
    for (int k = 2; k <= 257; k++) begin
      cprev = (k - 1 > 255) ? 8'd255 : 8'(k - 1);
      cnow  = (k > 255) ? 8'd255 : 8'(k);
      step("sat_ra",    3'b110, 0, 0, 0, 1, 1, cprev);
      step("sat_green", 3'b001, 0, 0, 0, 1, 2, cprev);
      step("sat_amber", 3'b010, 0, 0, 0, 1, 3, cprev);
      step("sat_red",   3'b100, 0, 0, 0, 1, 0, cnow);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
